// File: rtl/bk_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Stage 1 forms p/g, stage 2 holds the up-sweep tree, stage 3 resolves carries and flags.
module bk_adder_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int LOG = $clog2(WIDTH);

  generate
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : gen_bad_width
      $error("bk_adder_pipe: WIDTH must be a power of 2 and >= 4");
    end
  endgenerate

  // Handshake: a beat moves on any edge where valid && ready. A stage loads when
  // it is empty or the stage after it loads, so bubbles collapse under stall and
  // in_ready depends only on pipeline state, never on in_valid.
  logic v1, v2, v3;
  logic en1, en2, en3;

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  // Stage 1: subtract is A + ~B + ~borrow
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p1, g1;
  logic             c0_1;

  assign bx = sub ? ~b : b;

  always_ff @(posedge clk) begin
    if (en1) begin
      p1   <= a ^ bx;
      g1   <= a & bx;
      c0_1 <= sub ? ~cin : cin;
    end
  end

  // Up-sweep: at level l, node i (with i+1 a multiple of 2^l) absorbs the group
  // ending 2^(l-1) below it; other positions pass their level l-1 value through.
  for (genvar l = 0; l <= LOG; l++) begin : gen_up
    logic [WIDTH-1:0] gv, pv;
    if (l == 0) begin : gen_base
      assign gv = g1;
      assign pv = p1;
    end else begin : gen_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        if (((i + 1) % (1 << l)) == 0) begin : gen_node
          assign gv[i] = gen_up[l-1].gv[i] |
                         (gen_up[l-1].pv[i] & gen_up[l-1].gv[i - (1 << (l - 1))]);
          assign pv[i] = gen_up[l-1].pv[i] & gen_up[l-1].pv[i - (1 << (l - 1))];
        end else begin : gen_pass
          assign gv[i] = gen_up[l-1].gv[i];
          assign pv[i] = gen_up[l-1].pv[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] up_g2, up_p2, p2;
  logic             c0_2;

  always_ff @(posedge clk) begin
    if (en2) begin
      up_g2 <= gen_up[LOG].gv;
      up_p2 <= gen_up[LOG].pv;
      p2    <= p1;
      c0_2  <= c0_1;
    end
  end

  // Down-sweep: node i covers bits (i-span+1..i) with span = lowest set bit of
  // i+1; its carry-out chains off the carry at i-span, or off c0 for a full prefix.
  logic [WIDTH-1:0] carry;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_dn
    localparam int SPAN = (i + 1) & ~i;
    logic c_node;
    if (SPAN == i + 1) begin : gen_root
      assign c_node = up_g2[i] | (up_p2[i] & c0_2);
    end else begin : gen_fill
      assign c_node = up_g2[i] | (up_p2[i] & gen_dn[i-SPAN].c_node);
    end
    assign carry[i] = c_node;
  end

  logic [WIDTH-1:0] sum_next;
  assign sum_next = p2 ^ {carry[WIDTH-2:0], c0_2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (en3) begin
      sum  <= sum_next;
      cout <= carry[WIDTH-1];
      ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
      zero <= (sum_next == '0);
    end
  end

endmodule
